imem_loader: RTL

Program loader that feeds the instruction memory from a byte-wide ready/valid stream. It accepts a 16-bit word count followed by big-endian instruction words, assembles them, and issues single-cycle word writes to instruction memory at byte addresses 0, 4, 8, ….
- It is the write side of the read-only instruction memory used by the IF stage.
- It holds the CPU in stall (`cpu_hold`) while loading.
- It signals completion or error to the test/boot controller.

---
 rtl/imem_loader.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Instruction-memory loader: byte stream (16-bit BE count + BE words) -> word writes at 0,4,8...
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
  parameter int unsigned DEPTH = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_DONE
`ifdef IMEM_LOADER_CHECKSUM_EN
    , S_CSUM
`endif
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [IDX_W-1:0]   word_idx_q, word_idx_d;
  logic [1:0]         byte_cnt_q, byte_cnt_d;
  logic [23:0]        asm_q, asm_d;
  logic               byte_ready_q, byte_ready_d;
  logic               wr_en_q, wr_en_d;
  logic [31:0]        wr_addr_q, wr_addr_d;
  logic [31:0]        wr_data_q, wr_data_d;
  logic               cpu_hold_q, cpu_hold_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]         csum_q, csum_d;
`endif

  logic               xfer;
  logic               last_word;
  logic [CNT_W-1:0]   len_full;

  assign xfer      = byte_valid && byte_ready_q;
  assign last_word = (CNT_W'(word_idx_q) == (count_q - CNT_W'(1)));
  assign len_full  = {count_q[15:8], byte_in};

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      word_idx_q   <= '0;
      byte_cnt_q   <= '0;
      asm_q        <= '0;
      byte_ready_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      cpu_hold_q   <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      word_idx_q   <= word_idx_d;
      byte_cnt_q   <= byte_cnt_d;
      asm_q        <= asm_d;
      byte_ready_q <= byte_ready_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      cpu_hold_q   <= cpu_hold_d;
      done_q       <= done_d;
      err_q        <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    word_idx_d = word_idx_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    done_d     = 1'b0;
    err_d      = err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_LEN_HI;
          err_d      = 1'b0;
          word_idx_d = '0;
          byte_cnt_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d     = '0;
`endif
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          count_d[15:8] = byte_in;
          state_d       = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          count_d[7:0] = byte_in;
          if (len_full == '0) begin
            state_d = S_DONE;
          end else if (len_full > CNT_W'(DEPTH)) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          asm_d      = {asm_q[15:0], byte_in};
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d     = csum_q ^ byte_in;
`endif
          // Fourth byte completes the word; the write lands next cycle
          if (byte_cnt_q == 2'd3) begin
            wr_en_d    = 1'b1;
            wr_data_d  = {asm_q, byte_in};
            wr_addr_d  = 32'({word_idx_q, 2'b00});
            word_idx_d = word_idx_q + IDX_W'(1);
            if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_d = S_CSUM;
`else
              state_d = S_DONE;
`endif
            end
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (xfer) begin
          if (byte_in == csum_q) begin
            state_d = S_DONE;
          end else begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
`endif
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    byte_ready_d = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) || (state_d == S_DATA)
`ifdef IMEM_LOADER_CHECKSUM_EN
                   || (state_d == S_CSUM)
`endif
                   ;
    cpu_hold_d   = (state_d != S_IDLE);
  end

  assign byte_ready = byte_ready_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign cpu_hold   = cpu_hold_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule
